// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one single-port grayscale RAM between the
// VGA display path (always served at once) and the convolution engine's read
// and write ports (req/grant, round-robin between themselves).
module fb_port_arbiter #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    output logic [PIX_W-1:0]  vga_pixel,
    output logic              vga_valid,
    input  logic              conv_rd_req,
    input  logic [9:0]        conv_rd_x,
    input  logic [9:0]        conv_rd_y,
    output logic              conv_rd_grant,
    output logic [PIX_W-1:0]  conv_rd_data,
    output logic              conv_rd_valid,
    input  logic              conv_wr_req,
    input  logic [9:0]        conv_wr_x,
    input  logic [9:0]        conv_wr_y,
    input  logic [PIX_W-1:0]  conv_wr_data,
    output logic              conv_wr_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [15:0]       conv_stall_cnt
);

    // Tag of the read whose RAM data arrives next cycle; *_ZERO marks an
    // out-of-range read whose result is forced to 0.
    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_VGA,
        TAG_VGA_ZERO,
        TAG_CONV,
        TAG_CONV_ZERO
    } tag_t;

    localparam logic [9:0] IMG_W_C = 10'(IMG_W);
    localparam logic [9:0] IMG_H_C = 10'(IMG_H);

    tag_t              tag_q, tag_d;
    logic              rr_wr_q, rr_wr_d;      // 1: a tie goes to the write port
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  vga_pix_q, vga_pix_d;
    logic [PIX_W-1:0]  rd_pix_q, rd_pix_d;
    logic [15:0]       stall_q, stall_d;

    logic              vga_gnt, rd_gnt, wr_gnt, any_gnt, in_range, conv_pending;
    logic [9:0]        sel_x, sel_y;
    logic [ADDR_W-1:0] lin_addr;

    // Grant decision, address mux and all combinational outputs; everything
    // is held at 0 while reset is asserted.
    always_comb begin
        conv_pending = conv_rd_req | conv_wr_req;
        vga_gnt = vga_req & ~reset;
        rd_gnt  = ~reset & ~vga_req & conv_rd_req & (~conv_wr_req | ~rr_wr_q);
        wr_gnt  = ~reset & ~vga_req & conv_wr_req & (~conv_rd_req |  rr_wr_q);
        any_gnt = vga_gnt | rd_gnt | wr_gnt;

        sel_x = conv_wr_x;
        sel_y = conv_wr_y;
        if (vga_gnt) begin
            sel_x = vga_x;
            sel_y = vga_y;
        end else if (rd_gnt) begin
            sel_x = conv_rd_x;
            sel_y = conv_rd_y;
        end
        in_range = (sel_x < IMG_W_C) && (sel_y < IMG_H_C);
        lin_addr = ADDR_W'(sel_y) * ADDR_W'(IMG_W) + ADDR_W'(sel_x);

        conv_rd_grant = rd_gnt;
        conv_wr_grant = wr_gnt;
        mem_addr      = any_gnt ? lin_addr : addr_q;
        mem_we        = wr_gnt & in_range;
        mem_wdata     = wr_gnt ? conv_wr_data : '0;

        // Response side: data from the RAM lines up with the registered tag.
        vga_valid     = (tag_q == TAG_VGA)  || (tag_q == TAG_VGA_ZERO);
        conv_rd_valid = (tag_q == TAG_CONV) || (tag_q == TAG_CONV_ZERO);
        vga_pixel     = vga_pix_q;
        if (vga_valid)
            vga_pixel = (tag_q == TAG_VGA) ? mem_rdata : '0;
        conv_rd_data  = rd_pix_q;
        if (conv_rd_valid)
            conv_rd_data = (tag_q == TAG_CONV) ? mem_rdata : '0;
        conv_stall_cnt = stall_q;
    end

    // Next-state values for the tag, pointer, held address/data and stall counter.
    always_comb begin
        tag_d = TAG_NONE;
        if (vga_gnt)
            tag_d = in_range ? TAG_VGA : TAG_VGA_ZERO;
        else if (rd_gnt)
            tag_d = in_range ? TAG_CONV : TAG_CONV_ZERO;

        rr_wr_d = rr_wr_q;
        if (wr_gnt)
            rr_wr_d = 1'b0;
        else if (rd_gnt)
            rr_wr_d = 1'b1;

        addr_d    = mem_addr;
        vga_pix_d = vga_pixel;
        rd_pix_d  = conv_rd_data;

        stall_d = stall_q;
        if (vga_gnt && conv_pending && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    // State registers; reset discards any in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q     <= TAG_NONE;
            rr_wr_q   <= 1'b1;
            addr_q    <= '0;
            vga_pix_q <= '0;
            rd_pix_q  <= '0;
            stall_q   <= '0;
        end else begin
            tag_q     <= tag_d;
            rr_wr_q   <= rr_wr_d;
            addr_q    <= addr_d;
            vga_pix_q <= vga_pix_d;
            rd_pix_q  <= rd_pix_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed testbench for fb_port_arbiter with a write-first RAM model.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vga_req = 1'b0;
    logic [9:0]  vga_x = '0, vga_y = '0;
    logic [3:0]  vga_pixel;
    logic        vga_valid;
    logic        conv_rd_req = 1'b0;
    logic [9:0]  conv_rd_x = '0, conv_rd_y = '0;
    logic        conv_rd_grant;
    logic [3:0]  conv_rd_data;
    logic        conv_rd_valid;
    logic        conv_wr_req = 1'b0;
    logic [9:0]  conv_wr_x = '0, conv_wr_y = '0;
    logic [3:0]  conv_wr_data = '0;
    logic        conv_wr_grant;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata = '0;
    logic [15:0] conv_stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] ram [0:(1<<19)-1];

    fb_port_arbiter dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
        .vga_pixel(vga_pixel), .vga_valid(vga_valid),
        .conv_rd_req(conv_rd_req), .conv_rd_x(conv_rd_x), .conv_rd_y(conv_rd_y),
        .conv_rd_grant(conv_rd_grant), .conv_rd_data(conv_rd_data), .conv_rd_valid(conv_rd_valid),
        .conv_wr_req(conv_wr_req), .conv_wr_x(conv_wr_x), .conv_wr_y(conv_wr_y),
        .conv_wr_data(conv_wr_data), .conv_wr_grant(conv_wr_grant),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conv_stall_cnt(conv_stall_cnt)
    );

    always #5 clk = ~clk;

    // Write-first synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (vga_valid !== 1'b0) begin n_bad++; $display("FAIL rst_vga_valid: got %0h want 0", vga_valid); end
        n_cmp++; if (conv_rd_grant !== 1'b0 || conv_wr_grant !== 1'b0) begin n_bad++; $display("FAIL rst_grants: got rd=%0h wr=%0h want 0", conv_rd_grant, conv_wr_grant); end
        n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 19'd0) begin n_bad++; $display("FAIL rst_mem: got we=%0h addr=%0d want 0", mem_we, mem_addr); end
        n_cmp++; if (conv_stall_cnt !== 16'd0 || vga_pixel !== 4'd0 || conv_rd_data !== 4'd0) begin n_bad++; $display("FAIL rst_data: got stall=%0d pix=%0h rd=%0h want 0", conv_stall_cnt, vga_pixel, conv_rd_data); end
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_vga_read();
        ram[1283] = 4'hA;
        vga_req = 1'b1; vga_x = 10'd3; vga_y = 10'd2;
        #1;
        n_cmp++; if (mem_addr !== 19'd1283 || mem_we !== 1'b0) begin n_bad++; $display("FAIL vga_addr: got addr=%0d we=%0h want 1283/0", mem_addr, mem_we); end
        step();
        vga_req = 1'b0;
        n_cmp++; if (vga_valid !== 1'b1 || vga_pixel !== 4'hA) begin n_bad++; $display("FAIL vga_data: got valid=%0h pix=%0h want 1/a", vga_valid, vga_pixel); end
        repeat (4) step();
        n_cmp++; if (vga_valid !== 1'b0 || vga_pixel !== 4'hA) begin n_bad++; $display("FAIL vga_hold: got valid=%0h pix=%0h want 0/a", vga_valid, vga_pixel); end
        $display("vga read (3,2) -> %0h", vga_pixel);
    endtask

    task automatic test_read_after_write();
        conv_wr_req = 1'b1; conv_wr_x = 10'd10; conv_wr_y = 10'd0; conv_wr_data = 4'h7;
        conv_rd_req = 1'b1; conv_rd_x = 10'd10; conv_rd_y = 10'd0;
        #1;
        n_cmp++; if (conv_wr_grant !== 1'b1 || conv_rd_grant !== 1'b0) begin n_bad++; $display("FAIL raw_wr_first: got wr=%0h rd=%0h want 1/0", conv_wr_grant, conv_rd_grant); end
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 19'd10 || mem_wdata !== 4'h7) begin n_bad++; $display("FAIL raw_wr_bus: got we=%0h addr=%0d wd=%0h want 1/10/7", mem_we, mem_addr, mem_wdata); end
        step();
        conv_wr_req = 1'b0;
        #1;
        n_cmp++; if (conv_rd_grant !== 1'b1 || conv_wr_grant !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL raw_rd_grant: got rd=%0h wr=%0h we=%0h want 1/0/0", conv_rd_grant, conv_wr_grant, mem_we); end
        step();
        conv_rd_req = 1'b0;
        n_cmp++; if (conv_rd_valid !== 1'b1 || conv_rd_data !== 4'h7 || vga_valid !== 1'b0) begin n_bad++; $display("FAIL raw_rd_data: got valid=%0h data=%0h vv=%0h want 1/7/0", conv_rd_valid, conv_rd_data, vga_valid); end
        $display("conv write (10,0)=7 then read -> %0h", conv_rd_data);
    endtask

    task automatic test_stall();
        vga_req = 1'b1; vga_x = 10'd0; vga_y = 10'd0;
        conv_rd_req = 1'b1; conv_rd_x = 10'd1; conv_rd_y = 10'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (conv_rd_grant !== 1'b0) begin n_bad++; $display("FAIL stall_blocked[%0d]: got %0h want 0", i, conv_rd_grant); end
            step();
        end
        vga_req = 1'b0;
        #1;
        n_cmp++; if (conv_rd_grant !== 1'b1) begin n_bad++; $display("FAIL stall_grant: got %0h want 1", conv_rd_grant); end
        n_cmp++; if (conv_stall_cnt !== 16'd3) begin n_bad++; $display("FAIL stall_cnt: got %0d want 3", conv_stall_cnt); end
        step();
        conv_rd_req = 1'b0;
        #1;
        n_cmp++; if (conv_stall_cnt !== 16'd3) begin n_bad++; $display("FAIL stall_cnt_hold: got %0d want 3", conv_stall_cnt); end
        $display("conv read stalled 3 cycles by vga, stall=%0d", conv_stall_cnt);
    endtask

    task automatic test_fairness();
        conv_wr_req = 1'b1; conv_wr_x = 10'd20; conv_wr_y = 10'd5; conv_wr_data = 4'hC;
        conv_rd_req = 1'b1; conv_rd_x = 10'd20; conv_rd_y = 10'd5;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (conv_wr_grant !== ((i % 2) == 0) || conv_rd_grant !== ((i % 2) == 1)) begin
                n_bad++; $display("FAIL rr_grant[%0d]: got wr=%0h rd=%0h want wr=%0d", i, conv_wr_grant, conv_rd_grant, (i % 2) == 0);
            end
            step();
        end
        conv_wr_req = 1'b0; conv_rd_req = 1'b0;
        n_cmp++; if (conv_rd_valid !== 1'b1 || conv_rd_data !== 4'hC) begin n_bad++; $display("FAIL rr_rd_data: got valid=%0h data=%0h want 1/c", conv_rd_valid, conv_rd_data); end
        #1;
        n_cmp++; if (conv_wr_grant !== 1'b0 || conv_rd_grant !== 1'b0) begin n_bad++; $display("FAIL rr_idle: got wr=%0h rd=%0h want 0/0", conv_wr_grant, conv_rd_grant); end
        $display("round robin 8 grants W/R alternating");
    endtask

    task automatic test_out_of_range();
        ram[640] = 4'h5;
        vga_req = 1'b1; vga_x = 10'd640; vga_y = 10'd0;
        #1;
        n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 19'd640) begin n_bad++; $display("FAIL oor_vga_bus: got we=%0h addr=%0d want 0/640", mem_we, mem_addr); end
        step();
        vga_req = 1'b0;
        n_cmp++; if (vga_valid !== 1'b1 || vga_pixel !== 4'h0) begin n_bad++; $display("FAIL oor_vga_data: got valid=%0h pix=%0h want 1/0", vga_valid, vga_pixel); end
        ram[307200] = 4'h3;
        conv_wr_req = 1'b1; conv_wr_x = 10'd0; conv_wr_y = 10'd480; conv_wr_data = 4'h9;
        #1;
        n_cmp++; if (conv_wr_grant !== 1'b1 || mem_we !== 1'b0) begin n_bad++; $display("FAIL oor_wr: got grant=%0h we=%0h want 1/0", conv_wr_grant, mem_we); end
        step();
        conv_wr_req = 1'b0;
        #1;
        n_cmp++; if (conv_wr_grant !== 1'b0) begin n_bad++; $display("FAIL oor_wr_pulse: got %0h want 0", conv_wr_grant); end
        step();
        n_cmp++; if (ram[307200] !== 4'h3) begin n_bad++; $display("FAIL oor_ram: got %0h want 3", ram[307200]); end
        $display("out-of-range vga (640,0) and conv write (0,480)");
    endtask

    task automatic test_reset_mid();
        vga_req = 1'b1; vga_x = 10'd3; vga_y = 10'd2;
        step();
        vga_req = 1'b0;
        conv_rd_req = 1'b1; conv_rd_x = 10'd4; conv_rd_y = 10'd4;
        #1;
        n_cmp++; if (conv_rd_grant !== 1'b1) begin n_bad++; $display("FAIL mid_grant: got %0h want 1", conv_rd_grant); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        conv_rd_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (conv_rd_valid !== 1'b0 || vga_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got rd=%0h vga=%0h want 0/0", conv_rd_valid, vga_valid); end
        n_cmp++; if (vga_pixel !== 4'h0 || conv_rd_data !== 4'h0 || mem_addr !== 19'd0) begin n_bad++; $display("FAIL mid_outputs: got pix=%0h rd=%0h addr=%0d want 0", vga_pixel, conv_rd_data, mem_addr); end
        step();
        reset = 1'b0;
        step();
        n_cmp++; if (conv_rd_valid !== 1'b0 || conv_stall_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_after: got valid=%0h stall=%0d want 0/0", conv_rd_valid, conv_stall_cnt); end
        $display("reset during conv read in flight");
    endtask

    initial begin
        for (int i = 0; i < (1 << 19); i++) ram[i] = 4'h0;
        test_reset();
        test_vga_read();
        test_read_after_write();
        test_stall();
        test_fairness();
        test_out_of_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port grayscale frame-buffer RAM between the VGA display path and the convolution engine.
- The display side issues one-cycle pixel requests with x/y and is always served immediately.
- The convolution engine's read and write requests use a req/grant handshake and fill the remaining slots in round-robin order.
- Sits between VGA_output (pixel request side), the convolution datapath, and the frame-buffer BRAM.

Parameters:
IMG_W, 640, image width in pixels
IMG_H, 480, image height in lines
ADDR_W, 19, RAM address width (must hold IMG_W*IMG_H-1)
PIX_W, 4, grayscale pixel width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vga_req  in  1  one-cycle display pixel request
vga_x  in  10  display pixel column
vga_y  in  10  display pixel row
vga_pixel  out  PIX_W  returned display pixel
vga_valid  out  1  one-cycle pulse, vga_pixel valid
conv_rd_req  in  1  conv read request, held until granted
conv_rd_x  in  10  conv read column
conv_rd_y  in  10  conv read row
conv_rd_grant  out  1  read accepted this cycle
conv_rd_data  out  PIX_W  read data
conv_rd_valid  out  1  one-cycle pulse, conv_rd_data valid
conv_wr_req  in  1  conv write request, held until granted
conv_wr_x  in  10  conv write column
conv_wr_y  in  10  conv write row
conv_wr_data  in  PIX_W  write data
conv_wr_grant  out  1  write accepted this cycle
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  PIX_W  RAM write data
mem_rdata  in  PIX_W  RAM read data, one-cycle synchronous latency
conv_stall_cnt  out  16  saturating count of cycles a conv request was blocked by VGA

Behaviour:
- Reset state: all outputs 0, including grants, valids, mem_we, mem_addr, vga_pixel, conv_rd_data and conv_stall_cnt. The round-robin pointer favours write. The in-flight tag is NONE.
- Reset mid-operation: any in-flight read is discarded and no valid pulse follows reset release.
- Single access per cycle. The grant decision and the mem_addr/mem_we/mem_wdata outputs are combinational from the current requests.
- Grant decision, for cycle N:
  - Priority 1: vga_req=1 wins unconditionally.
  - Priority 2: otherwise, if exactly one conv request is pending, it wins.
  - Priority 3: if both conv requests are pending, round-robin decides. The pointer flips after every conv grant to point at the other type.
- Address: mem_addr = y*IMG_W + x, truncated to ADDR_W. When no request is granted, mem_addr holds its previous value.
- Out-of-range coordinates (x>=IMG_W or y>=IMG_H):
  - The request is still granted (for VGA, still accepted).
  - mem_we is forced to 0.
  - Reads return 0 instead of mem_rdata.
  - Writes are dropped silently.
- Grant pulses: conv_rd_grant and conv_wr_grant are each high for exactly one cycle per accepted request. The requester may change its request inputs from cycle N+1.
- Write: mem_we=1 in grant cycle N only, with mem_wdata=conv_wr_data. Writes produce no response.
- Read pipeline: the in-flight tag register (NONE, VGA, VGA_ZERO, CONV, CONV_ZERO) is loaded at N.
  - VGA read: vga_valid=1 at N+1, with vga_pixel = mem_rdata (0 for the ZERO tag). vga_pixel is registered and holds its value until the next vga_valid.
  - Conv read: conv_rd_valid=1 at N+1, with conv_rd_data following the same rules as VGA.
  - Back-to-back reads in consecutive cycles are legal and produce consecutive valid pulses.
- Simultaneous events:
  - VGA plus one or both conv requests: VGA granted; conv requests keep waiting.
  - conv_stall_cnt increments by 1 in every cycle where VGA is granted and at least one conv request is pending. It saturates at 16'hFFFF.
  - Round-robin pointer does not change on VGA-won cycles.
- Read-after-write to the same address in consecutive cycles returns the new data. The RAM must be configured write-first or no-change; the arbiter never grants read and write in the same cycle.
- The arbiter never drops a held conv request. Fairness: with both conv requests held continuously and no VGA traffic, grants alternate W, R, W, R.

Test Plan:
- Reset, then vga_req at (3,2) with RAM[1283]=4'hA -> mem_addr=1283 at N; vga_valid=1 and vga_pixel=4'hA at N+1; vga_pixel still 4'hA at N+5.
- conv_wr_req (10,0, data 4'h7) held with conv_rd_req (10,0) from cycle N -> wr_grant at N (pointer reset favours write); rd_grant at N+1; conv_rd_data=4'h7 with rd_valid at N+2.
- vga_req every cycle for 3 cycles while conv_rd_req held -> no conv_rd_grant during those 3 cycles; conv_stall_cnt=3; rd_grant on the 4th cycle.
- Out-of-range: vga_req (640,0) -> mem_we=0, vga_valid with vga_pixel=0. conv_wr at (0,480) -> wr_grant pulses, mem_we stays 0, RAM unchanged.
- Both conv requests held for 8 cycles with no VGA -> grants alternate W,R,W,R,W,R,W,R; each grant is a single-cycle pulse.
- Assert reset the cycle after a conv read grant -> no conv_rd_valid; all outputs 0; conv_stall_cnt=0 after release.
